// File: rtl/hpdcache_pkg.sv
// HPDcache request/response types shared by the CVA6-side adapters and the cache core.
// Types only: no logic, no latency, no flow control.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_SID_WIDTH = 3;
  localparam int unsigned HPDCACHE_TID_WIDTH = 4;

  typedef logic [31:0] hpdcache_tag_t;

  typedef struct packed {
    logic uncacheable;
    logic io;
  } hpdcache_pma_t;

  typedef struct packed {
    logic [11:0]                   addr_offset;
    logic [63:0]                   wdata;
    logic [3:0]                    op;
    logic [7:0]                    be;
    logic [2:0]                    size;
    logic [HPDCACHE_SID_WIDTH-1:0] sid;
    logic [HPDCACHE_TID_WIDTH-1:0] tid;
    logic                          need_rsp;
    logic                          phys_indexed;
  } hpdcache_req_t;

  typedef struct packed {
    logic [63:0]                   rdata;
    logic [HPDCACHE_SID_WIDTH-1:0] sid;
    logic [HPDCACHE_TID_WIDTH-1:0] tid;
    logic                          error;
    logic                          aborted;
  } hpdcache_rsp_t;

endpackage

// File: rtl/hpdcache_rr_sel.sv
// Rotate-priority selector: first set bit of req_i scanning upward from ptr_i, wrapping at N.
// Purely combinational, zero latency; no flow control of its own.
module hpdcache_rr_sel #(
  parameter int unsigned N    = 3,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/cva6_hpdcache_req_arbiter.sv
// Round-robin share of the HPDcache request port among NREQ requesters, with SID-steered responses.
// Zero-cycle request/response paths, second phase one cycle after handshake; a stalled grant is held locked.
module cva6_hpdcache_req_arbiter
  import hpdcache_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDXW = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] req_ready_o,
  input  hpdcache_req_t   req_i [NREQ],
  input  logic [NREQ-1:0] req_abort_i,
  input  hpdcache_tag_t   req_tag_i [NREQ],
  input  hpdcache_pma_t   req_pma_i [NREQ],
  output logic [NREQ-1:0] rsp_valid_o,
  output hpdcache_rsp_t   rsp_o,
  output logic            hpdcache_req_valid_o,
  input  logic            hpdcache_req_ready_i,
  output hpdcache_req_t   hpdcache_req_o,
  output logic            hpdcache_req_abort_o,
  output hpdcache_tag_t   hpdcache_req_tag_o,
  output hpdcache_pma_t   hpdcache_req_pma_o,
  input  logic            hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t   hpdcache_rsp_i
);

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;

  arb_state_t      lock_q, lock_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [IDXW-1:0] s1_idx_q, s1_idx_d;

  logic [NREQ-1:0] sel_req, gnt;
  logic [IDXW-1:0] sel_ptr, gnt_idx;
  logic            gnt_any, handshake;

  // While locked, only the locked requester is offered to the selector.
  always_comb begin
    sel_req = req_valid_i;
    sel_ptr = rr_ptr_q;
    if (lock_q == ARB_LOCKED) begin
      sel_req             = '0;
      sel_req[lock_idx_q] = req_valid_i[lock_idx_q];
      sel_ptr             = lock_idx_q;
    end
  end

  hpdcache_rr_sel #(
    .N    (NREQ),
    .IDXW (IDXW)
  ) i_rr_sel (
    .req_i (sel_req),
    .ptr_i (sel_ptr),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign handshake            = gnt_any & hpdcache_req_ready_i;
  assign hpdcache_req_valid_o = gnt_any;
  assign req_ready_o          = gnt & {NREQ{hpdcache_req_ready_i}};

  always_comb begin
    hpdcache_req_o     = req_i[gnt_idx];
    hpdcache_req_o.sid = HPDCACHE_SID_WIDTH'(gnt_idx);
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = 1'b0;
    s1_idx_d   = s1_idx_q;
    case (lock_q)
      ARB_IDLE: begin
        if (gnt_any && !hpdcache_req_ready_i) begin
          lock_d     = ARB_LOCKED;
          lock_idx_d = gnt_idx;
        end
      end
      ARB_LOCKED: begin
        // A requester withdrawing while locked is illegal, but must not wedge the port.
        if (handshake || !req_valid_i[lock_idx_q]) lock_d = ARB_IDLE;
      end
    endcase
    if (handshake) begin
      rr_ptr_d = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
      if (!req_i[gnt_idx].phys_indexed) begin
        s1_valid_d = 1'b1;
        s1_idx_d   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= ARB_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
    end
  end

  always_comb begin
    hpdcache_req_abort_o = 1'b0;
    hpdcache_req_tag_o   = '0;
    hpdcache_req_pma_o   = '0;
    if (s1_valid_q) begin
      hpdcache_req_abort_o = req_abort_i[s1_idx_q];
      hpdcache_req_tag_o   = req_tag_i[s1_idx_q];
      hpdcache_req_pma_o   = req_pma_i[s1_idx_q];
    end
  end

  // An out-of-range SID matches no requester, so the response is simply dropped.
  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid_o[i] = hpdcache_rsp_valid_i && (hpdcache_rsp_i.sid == HPDCACHE_SID_WIDTH'(i));
    end
  end

  assign rsp_o = hpdcache_rsp_i;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(lock_q == ARB_LOCKED && !req_valid_i[lock_idx_q]))
        else $error("requester %0d withdrew valid while locked", lock_idx_q);
      assert (!hpdcache_rsp_valid_i || (32'(hpdcache_rsp_i.sid) < NREQ))
        else $warning("response sid %0d has no requester, dropped", hpdcache_rsp_i.sid);
    end
  end
`endif

endmodule

// File: doc/cva6_hpdcache_req_arbiter.md
# cva6_hpdcache_req_arbiter

Round-robin arbiter that shares the single HPDcache core request port among NREQ CVA6-side requesters (load ports, store/AMO port, PTW). It sits between the per-port CVA6 interface adapters and the L1 data cache. It carries the one-cycle-late second phase (abort/tag/PMA) of virtually indexed requests, and steers responses back to the right requester by SID.

## Interface
Parameters:
- NREQ, 3, number of requesters, 2..8; requester i is assigned SID i.
- IDXW, $clog2(NREQ), width of the grant index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NREQ  per-requester request valid.
- req_ready_o  out  NREQ  per-requester ready.
- req_i  in  NREQ x hpdcache_req_t  per-requester request.
- req_abort_i  in  NREQ  second-phase abort, from the requester.
- req_tag_i  in  NREQ x hpdcache_tag_t  second-phase tag.
- req_pma_i  in  NREQ x hpdcache_pma_t  second-phase PMA.
- rsp_valid_o  out  NREQ  per-requester response valid.
- rsp_o  out  hpdcache_rsp_t  response payload, broadcast to all requesters.
- hpdcache_req_valid_o  out  1  request valid to the cache.
- hpdcache_req_ready_i  in  1  cache ready.
- hpdcache_req_o  out  hpdcache_req_t  granted request; sid is overwritten with the grant index.
- hpdcache_req_abort_o / hpdcache_req_tag_o / hpdcache_req_pma_o  out  1 / tag / pma  second phase to the cache.
- hpdcache_rsp_valid_i  in  1  response valid from the cache.
- hpdcache_rsp_i  in  hpdcache_rsp_t  response from the cache.

## Operation
- State:
  - rr_ptr (IDXW bits), reset 0.
  - lock_q (1 bit) and lock_idx_q (IDXW bits), reset 0.
  - s1_valid_q (1 bit) and s1_idx_q (IDXW bits), reset 0.
- Arbitration state machine, two states:
  - IDLE (lock_q=0): the grant goes to the first valid requester scanning from rr_ptr upward, wrapping modulo NREQ. Grant is combinational in the same cycle.
  - LOCKED (lock_q=1): the grant is forced to lock_idx_q; no re-arbitration.
  - IDLE->LOCKED: a grant is issued and hpdcache_req_ready_i=0. lock_idx_q captures the grant.
  - LOCKED->IDLE: handshake on the locked requester.
- A requester must hold req_valid_i and req_i stable until it sees ready. A requester dropping valid while locked is a protocol error (assertion); the lock is released anyway.
- Outputs:
  - hpdcache_req_valid_o = any grant.
  - hpdcache_req_o = req_i[grant], with sid = grant index.
  - req_ready_o[i] = hpdcache_req_ready_i & grant[i].
- On handshake, rr_ptr <= (grant+1) mod NREQ; wrap from NREQ-1 goes to 0.
- Second phase:
  - Handshake with phys_indexed=0: s1_valid_q<=1 and s1_idx_q<=grant.
  - Any other cycle: s1_valid_q<=0.
  - While s1_valid_q=1, abort/tag/pma outputs are muxed from index s1_idx_q. Otherwise they are 0.
- Response routing:
  - rsp_valid_o[i] = hpdcache_rsp_valid_i & (hpdcache_rsp_i.sid==i).
  - rsp_o = hpdcache_rsp_i.
  - SID >= NREQ: the response is dropped and an assertion fires.
- Simultaneous events: a request handshake and a response for the same requester in one cycle are independent; both proceed.

## Timing
- Request path: zero cycles, combinational from req_valid_i to hpdcache_req_valid_o.
- Second phase: exactly one cycle after the request handshake.
- Response path: zero cycles, no buffering.
- Back-to-back grants are allowed every cycle. A new first phase may coincide with the previous request's second phase.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - hpdcache_req_valid_o is 0 if no req_valid_i is high.
  - abort_o, tag_o and pma_o are 0.
  - rr_ptr returns to 0.
  - An in-flight second phase is lost; the requester must also be reset.
- Fairness: a continuously valid requester is granted within NREQ handshakes.

## Structure
- Shared package: none needed. hpdcache_req_t, hpdcache_rsp_t, hpdcache_tag_t and hpdcache_pma_t come from hpdcache_pkg.
- Sub-module hpdcache_rr_sel: a combinational rotate-priority selector. Inputs are a request vector and a pointer; outputs are a one-hot grant, the grant index and an any-grant flag. This block instantiates it once.
- Everything else stays inline: lock register, rr_ptr, second-phase register, response decode.

## Test plan
- Single requester 1, ready=1: grant the same cycle, sid=1. rr_ptr becomes 2. With phys_indexed=0, abort/tag/pma from requester 1 appear the next cycle and read 0 the cycle after.
- All three valid, ready always 1: grants are in order 0,1,2,0,1,2. NREQ-1 wraps to 0.
- Requester 2 granted with ready=0 for 3 cycles while requester 0 rises: the grant stays on 2. Requester 0 is granted the cycle after requester 2's handshake.
- Load handshake (phys_indexed=0) on requester 0 followed immediately by a store handshake on requester 1: the second phase carries requester 0's tag while the store is presented.
- Response with sid=1: only rsp_valid_o[1] is high. sid=3 with NREQ=3: no rsp_valid_o is high and the assertion fires.
- Reset asserted while locked and with s1_valid_q=1: the next cycle has no lock, second-phase outputs are 0 and rr_ptr=0.
